// File: rtl/nrisc_pc_stack.sv
// rtl/nrisc_pc_stack.sv - program counter with hardware return-address stack
// Optional interrupt entry (irq/irq_ack, ie bit) enabled by defining NRISC_PC_IRQ_EN.
module nrisc_pc_stack #(
  parameter int                ADDR_W       = 16,
  parameter int                DEPTH        = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
`ifdef NRISC_PC_IRQ_EN
  ,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(4)
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              PC_ctrl,
  input  logic                    PC_en,
  input  logic [ADDR_W-1:0]       PC_jump_in,
  input  logic [1:0]              STACK_ctrl,
`ifdef NRISC_PC_IRQ_EN
  input  logic                    irq,
  output logic                    irq_ack,
`endif
  output logic [ADDR_W-1:0]       PC_out,
  output logic [$clog2(DEPTH):0]  STACK_level,
  output logic                    STACK_full,
  output logic                    STACK_empty,
  output logic                    STACK_overflow,
  output logic                    STACK_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] ret_q;
  logic [LVL_W-1:0]  level_q;
  logic              ovf_q;
  logic              unf_q;
  logic [ADDR_W-1:0] mem [DEPTH];

  logic              full;
  logic              empty;
  logic              push_cmd;
  logic              pop_cmd;
  logic              clr_cmd;
  logic              irq_take;
  logic              do_push;
  logic              do_pop;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  pop_idx;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign push_cmd = (STACK_ctrl == 2'b01);
  assign pop_cmd  = (STACK_ctrl == 2'b10);
  assign clr_cmd  = (STACK_ctrl == 2'b11);

`ifdef NRISC_PC_IRQ_EN
  logic ie_q;

  // Interrupt entry only borrows an otherwise idle sequential-fetch cycle, and waits while the stack is full.
  assign irq_take = irq & ie_q & PC_en & (PC_ctrl == 2'b00) & (STACK_ctrl == 2'b00) & ~full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q    <= 1'b1;
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= irq_take;
      if (irq_take)
        ie_q <= 1'b0;
      else if (PC_en && (PC_ctrl == 2'b11))
        ie_q <= 1'b1;
    end
  end
`else
  assign irq_take = 1'b0;
`endif

  assign do_push  = (push_cmd | irq_take) & ~full;
  assign do_pop   = pop_cmd & ~empty;
  assign push_idx = level_q[PTR_W-1:0];
  assign pop_idx  = PTR_W'(level_q - LVL_W'(1));

  always_comb begin
    pc_d = pc_q;
    if (PC_en) begin
      unique case (PC_ctrl)
        2'b00:   pc_d = pc_q + ADDR_W'(1);
        2'b01:   pc_d = pc_q;
        2'b10:   pc_d = PC_jump_in;
        default: pc_d = ret_q;
      endcase
    end
`ifdef NRISC_PC_IRQ_EN
    if (irq_take)
      pc_d = IRQ_VECTOR;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      ret_q   <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (do_push)
        level_q <= level_q + LVL_W'(1);
      else if (do_pop)
        level_q <= level_q - LVL_W'(1);
      if (do_pop)
        ret_q <= mem[pop_idx];
      if (clr_cmd) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (push_cmd && full)
          ovf_q <= 1'b1;
        if (pop_cmd && empty)
          unf_q <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (rst && do_push)
      mem[push_idx] <= pc_q;
  end

  assign PC_out          = pc_q;
  assign STACK_level     = level_q;
  assign STACK_full      = full;
  assign STACK_empty     = empty;
  assign STACK_overflow  = ovf_q;
  assign STACK_underflow = unf_q;

endmodule

// File: doc/nrisc_pc_stack.md
Name: nrisc_pc_stack

Overview:
Program-counter and return-address-stack unit. It is the responder for the CPU control unit's PC_ctrl, PC update strobe and STACK_ctrl commands. It holds the fetch address and a hardware LIFO of return addresses for CALL, RET and RETI, and reports stack status back to the control unit.

Parameters:
ADDR_W, 16, width of the PC, the jump input and each stack entry.
DEPTH, 8, number of stack entries; must be a power of two and at least 2.
RESET_VECTOR, 16'h0000, PC value loaded on reset.
IRQ_VECTOR, 16'h0004, PC value on interrupt entry; used only with the optional feature.

Ports:
clk  in  1  main clock; all state updates on posedge.
rst  in  1  asynchronous reset, active-low.
PC_ctrl  in  2  PC source select. 00 = PC+1; 01 = hold; 10 = load PC_jump_in (JMP/CALL target from ULA); 11 = load ret_addr (RET/RETI).
PC_en  in  1  synchronous update strobe; PC changes only on a clk edge where PC_en=1.
PC_jump_in  in  ADDR_W  jump target.
STACK_ctrl  in  2  stack command, acted on every edge. 00 = none; 01 = push PC_out; 10 = pop into ret_addr; 11 = clear error flags.
PC_out  out  ADDR_W  current fetch address.
STACK_level  out  clog2(DEPTH)+1  number of valid entries.
STACK_full  out  1  level==DEPTH, combinational from level.
STACK_empty  out  1  level==0, combinational from level.
STACK_overflow  out  1  sticky; set by a push while full.
STACK_underflow  out  1  sticky; set by a pop while empty.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-operation):
  - PC_out=RESET_VECTOR.
  - level=0, ret_addr=0, overflow=0, underflow=0.
  - Stack RAM contents are don't-care.
  - Release is sampled on the next posedge.
- PC update on a posedge with PC_en=1, per PC_ctrl:
  - 00: PC+1, modulo 2^ADDR_W (all-ones wraps to 0).
  - 01: PC unchanged.
  - 10: PC_jump_in.
  - 11: ret_addr value from before the edge.
- PC_en=0: PC holds regardless of PC_ctrl.
- Push (01):
  - If not full: mem[level] <= PC_out as it was before the edge, then level+1.
  - If full: no write, level unchanged, overflow <= 1.
- Pop (10):
  - If not empty: ret_addr <= mem[level-1], level-1.
  - If empty: ret_addr and level unchanged, underflow <= 1.
- Clear (11): overflow and underflow <= 0; level is untouched.
- Simultaneous events:
  - Push with a PC update in the same edge: the pre-update PC is pushed. CALL = push plus load 10 in one cycle.
  - Pop and PC_ctrl=11 in the same edge: the PC takes the old ret_addr. The CPU must therefore pop first and load on a later edge (RET = pop cycle, then load cycle).
- Latency:
  - Every command takes effect at the edge where it is sampled.
  - Outputs are registered, except full and empty.
- No internal FSM beyond the level counter; the control unit sequences multi-cycle ops.

Optional Feature:
NRISC_PC_IRQ_EN
- Adds ports irq (in, 1, level request) and irq_ack (out, 1, reset 0), plus an internal ie bit (reset 1).
- Entry: when irq=1, ie=1, PC_en=1, PC_ctrl=00, STACK_ctrl=00 and the stack is not full, that edge:
  - pushes PC_out;
  - sets PC <= IRQ_VECTOR;
  - clears ie;
  - pulses irq_ack high for exactly one cycle.
- If the stack is full, the interrupt is deferred; no overflow flag is set.
- ie is set again on the edge performing PC_ctrl=11 with PC_en=1 (RETI path). A nested irq while ie=0 is ignored.
- Without the macro: no irq/irq_ack ports, no ie logic, and behaviour is exactly as above.

Test Plan:
1. Reset low mid-count with PC=0x0123 -> PC_out=0x0000 and level=0 immediately (before any clk edge); after release, 3 edges of PC_en=1, ctrl=00 -> PC_out=0x0003.
2. PC=0xFFFF, PC_en=1, ctrl=00 -> PC_out=0x0000; PC_en=0 with ctrl=10 -> PC unchanged.
3. PC=0x0010, one edge with STACK_ctrl=01, PC_ctrl=10, PC_jump_in=0x0200 -> PC_out=0x0200, level=1. Then pop (10) -> level=0. Then ctrl=11 with PC_en=1 -> PC_out=0x0010.
4. 8 pushes of 0x0001..0x0008 -> full=1; 9th push -> overflow=1, level=8. 8 pops return 0x0008 down to 0x0001 in order; 9th pop -> underflow=1, ret_addr stays 0x0001. STACK_ctrl=11 -> both flags 0.
5. Pop on the same edge as PC_ctrl=11 with ret_addr=0x0AAA and top entry 0x0BBB -> PC_out=0x0AAA, ret_addr=0x0BBB.
6. (NRISC_PC_IRQ_EN) PC=0x0040, irq=1, ctrl=00, PC_en=1 -> PC_out=0x0004, irq_ack high one cycle, top entry=0x0040. A second irq is ignored. Pop then ctrl=11 -> PC_out=0x0040 and ie=1.
